// File: rtl/uart_pkg.sv
// Shared types for the byte-level UART link: FSM state encoding and
// baud-divider derivation used by both transmitter and receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

   // Integer division is intentional: the baud error is absorbed by
   // sampling at bit centres.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_if.sv
// Byte/serial signal bundle between the transceiver control layer and uart_core.
interface uart_if;

   logic [7:0] data_in;
   logic       wr_en;
   logic       Tx;
   logic       Tx_busy;
   logic       Rx;
   logic       Rx_ready;
   logic [7:0] data_out;

   modport master (
      output data_in, wr_en, Rx,
      input  Tx, Tx_busy, Rx_ready, data_out
   );

   modport slave (
      input  data_in, wr_en, Rx,
      output Tx, Tx_busy, Rx_ready, data_out
   );

endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver with 2-flop input synchronizer, mid-bit sampling, glitch
// rejection on the start bit and framing-error discard.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       rx_ready,
   output logic [7:0] data_out
);

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   uart_state_e      state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             rx_s1;
   logic             rx_s2;
   logic             ferr;
   logic             bit_end;

   assign bit_end = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (state == DATA && bit_end)
         shreg <= {rx_s2, shreg[7:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Synchronizer resets to the idle line level to avoid a false start
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         ferr     <= 1'b0;
         rx_ready <= 1'b0;
         data_out <= 8'h00;
      end else begin
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s2) begin
                  cnt   <= '0;
                  state <= START;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s2 ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7)
                     state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (ferr) begin
                  // Framing error: hold off until the line returns high
                  if (rx_s2) begin
                     ferr  <= 1'b0;
                     state <= IDLE;
                  end
               end else if (bit_end) begin
                  cnt <= '0;
                  if (rx_s2) begin
                     data_out <= shreg;
                     rx_ready <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     ferr <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: active-low level-sensitive write request, back-to-back
// frames while the request stays low.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       wr_en,
   output logic       tx,
   output logic       tx_busy
);

   localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   uart_state_e      state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             bit_end;
   logic             load;
   logic             shift;

   assign bit_end = (cnt == CNT_LAST);
   // A new frame may start from IDLE or straight out of STOP, giving no idle gap.
   assign load    = !wr_en && ((state == IDLE) || (state == STOP && bit_end));
   assign shift   = (state == DATA) && bit_end;

   always_ff @(posedge clk) begin
      if (load)
         shreg <= data_in;
      else if (shift)
         shreg <= shreg >> 1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!wr_en) begin
                  tx      <= 1'b0;
                  tx_busy <= 1'b1;
                  cnt     <= '0;
                  state   <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  tx      <= shreg[0];
                  state   <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     // shreg shifts on this same edge, so bit 1 is the next one out
                     tx      <= shreg[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (!wr_en) begin
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     tx_busy <= 1'b0;
                     state   <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one
// clock and a fixed baud divider.
module uart_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input logic clk,
   input logic rst_n,
   uart_if.slave bus
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_in (bus.data_in),
      .wr_en   (bus.wr_en),
      .tx      (bus.Tx),
      .tx_busy (bus.Tx_busy)
   );

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (bus.Rx),
      .rx_ready (bus.Rx_ready),
      .data_out (bus.data_out)
   );

endmodule

// File: tb/tb_uart_core.sv
// Directed + randomized bench for uart_core at 10 clocks per bit, checked
// against a frame-level model of the serial line.
module tb_uart_core;

   logic clk = 1'b0;
   logic rst_n;
   logic rx_drv = 1'b1;
   logic loopback = 1'b0;

   uart_if bus ();

   assign bus.Rx = loopback ? bus.Tx : rx_drv;

   uart_core #(
      .CLK_FREQ(1000),
      .BAUD    (100)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   int         rx_pulses;
   int         rx_pulse_at;
   logic [7:0] rx_cap;
   logic [7:0] exp_dout;
   logic [7:0] b;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line level of bit slot k (0 = start, 1..8 = data LSB first, 9 = stop).
   function automatic logic frame_bit(input logic [7:0] d, input int k, input logic stop);
      if (k == 0) return 1'b0;
      if (k == 9) return stop;
      return d[k-1];
   endfunction

   task automatic mon(input int i);
      if (bus.Rx_ready === 1'b1) begin
         rx_pulses++;
         rx_cap      = bus.data_out;
         rx_pulse_at = i;
      end
   endtask

   // Send one frame (or two back-to-back with wr_en held low) and check the
   // Tx waveform clock by clock; also tallies any receive pulses meanwhile.
   task automatic tx_seq(input logic [7:0] b0, input logic [7:0] b1, input bit two);
      int         nf;
      logic [7:0] cur;
      nf          = two ? 2 : 1;
      rx_pulses   = 0;
      bus.data_in = b0;
      bus.wr_en   = 1'b0;
      for (int i = 0; i < nf * 100; i++) begin
         @(negedge clk);
         mon(i);
         if (i == 0) begin
            if (two) bus.data_in = b1;
            else begin
               bus.wr_en   = 1'b1;
               bus.data_in = ~b0;
            end
         end
         if (two && i == 150) bus.wr_en = 1'b1;
         cur = (i < 100) ? b0 : b1;
         chk("tx_line", int'(bus.Tx), int'(frame_bit(cur, (i % 100) / 10, 1'b1)));
         chk("tx_busy", int'(bus.Tx_busy), 1);
      end
      @(negedge clk);
      mon(nf * 100);
      chk("tx_busy_end", int'(bus.Tx_busy), 0);
      chk("tx_idle", int'(bus.Tx), 1);
   endtask

   task automatic rx_frame(input logic [7:0] d, input logic stop);
      rx_pulses = 0;
      for (int i = 0; i < 130; i++) begin
         rx_drv = (i < 100) ? frame_bit(d, i / 10, stop) : 1'b1;
         @(negedge clk);
         mon(i);
      end
   endtask

   task automatic rx_good(input logic [7:0] d);
      rx_frame(d, 1'b1);
      exp_dout = d;
      chk("rx_pulses", rx_pulses, 1);
      chk("rx_data", int'(rx_cap), int'(d));
      chk("rx_latency", int'(rx_pulse_at >= 96 && rx_pulse_at <= 98), 1);
      chk("rx_hold", int'(bus.data_out), int'(exp_dout));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      bus.wr_en   = 1'b1;
      bus.data_in = 8'h00;
      exp_dout    = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_tx", int'(bus.Tx), 1);
      chk("rst_busy", int'(bus.Tx_busy), 0);
      chk("rst_ready", int'(bus.Rx_ready), 0);
      chk("rst_dout", int'(bus.data_out), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Transmit: single, back-to-back, random
      tx_seq(8'hA5, 8'h00, 1'b0);
      tx_seq(8'h55, 8'h3C, 1'b1);
      for (int n = 0; n < 2; n++) tx_seq(8'($urandom), 8'h00, 1'b0);

      // Receive: valid frame, glitch, framing error, random
      rx_good(8'hC3);
      rx_pulses = 0;
      for (int i = 0; i < 40; i++) begin
         rx_drv = (i < 3) ? 1'b0 : 1'b1;
         @(negedge clk);
         mon(i);
      end
      chk("glitch_pulses", rx_pulses, 0);
      chk("glitch_hold", int'(bus.data_out), int'(exp_dout));
      rx_frame(8'h7E, 1'b0);
      chk("ferr_pulses", rx_pulses, 0);
      chk("ferr_hold", int'(bus.data_out), int'(exp_dout));
      for (int n = 0; n < 4; n++) rx_good(8'($urandom));

      // Loopback
      loopback = 1'b1;
      for (int n = 0; n < 5; n++) begin
         case (n)
            0: b = 8'h00;
            1: b = 8'hFF;
            2: b = 8'h81;
            default: b = 8'($urandom);
         endcase
         tx_seq(b, 8'h00, 1'b0);
         exp_dout = b;
         chk("lb_pulses", rx_pulses, 1);
         chk("lb_data", int'(rx_cap), int'(b));
         chk("lb_hold", int'(bus.data_out), int'(exp_dout));
      end

      // Mid-frame reset, then a clean frame
      bus.data_in = 8'($urandom);
      bus.wr_en   = 1'b0;
      @(negedge clk);
      bus.wr_en = 1'b1;
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_dout = 8'h00;
      chk("mid_rst_tx", int'(bus.Tx), 1);
      chk("mid_rst_busy", int'(bus.Tx_busy), 0);
      chk("mid_rst_ready", int'(bus.Rx_ready), 0);
      chk("mid_rst_dout", int'(bus.data_out), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      b = 8'($urandom);
      tx_seq(b, 8'h00, 1'b0);
      chk("post_rst_pulses", rx_pulses, 1);
      chk("post_rst_data", int'(rx_cap), int'(b));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
